// File: rtl/plot_sink.sv
// Pixel plot sink: queues range-checked plot requests and drains them as linear
// framebuffer writes over a ready/valid port; also performs full-screen clear sweeps.
module plot_sink #(
  parameter int unsigned DEPTH        = 8,
  parameter int unsigned SCREEN_W     = 160,
  parameter int unsigned SCREEN_H     = 120,
  parameter logic [2:0]  CLEAR_COLOUR = 3'b000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [7:0]  x,
  input  logic [6:0]  y,
  input  logic [2:0]  colour,
  input  logic        plot,
  input  logic        clear_req,
  input  logic        clr_flags,
  output logic        full,
  output logic        busy,
  output logic [14:0] mem_addr,
  output logic [2:0]  mem_data,
  output logic        mem_we,
  input  logic        mem_ready,
  output logic        overflow,
  output logic [7:0]  drop_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned EW = 18;
  localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
  localparam logic [14:0]   LAST_ADDR = 15'(SCREEN_W * SCREEN_H - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRAIN = 2'd1,
    S_CLEAR = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic          clear_pending_q, clear_pending_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          mem_we_q, mem_we_d;
  logic [14:0]   mem_addr_q, mem_addr_d;
  logic [2:0]    mem_data_q, mem_data_d;
  logic          overflow_q, overflow_d;
  logic [7:0]    drop_count_q, drop_count_d;

  logic [EW-1:0] fifo_mem [DEPTH];

  logic          in_range;
  logic          push;
  logic          xfer;
  logic          pop;
  logic [14:0]   push_addr;
  logic [CW-1:0] avail;
  logic [EW-1:0] head;

  assign in_range  = (32'(x) < SCREEN_W) && (32'(y) < SCREEN_H);
  assign full      = (count_q == DEPTH_C) | clear_pending_q | (state_q == S_CLEAR);
  assign busy      = (state_q != S_IDLE) | clear_pending_q;
  assign push      = plot & ~full & in_range;
  assign xfer      = mem_we_q & mem_ready;
  assign pop       = xfer & (state_q == S_DRAIN);
  assign push_addr = (15'(y) << 7) + (15'(y) << 5) + 15'(x);

  assign wr_ptr_d  = wr_ptr_q + AW'(push);
  assign rd_ptr_d  = rd_ptr_q + AW'(pop);
  assign count_d   = count_q + CW'(push) - CW'(pop);
  // Entries stored before this edge; a same-cycle push is not yet presentable.
  assign avail     = count_q - CW'(pop);
  assign head      = fifo_mem[rd_ptr_d];

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= {push_addr, colour};
  end

  // Next-state and registered output stage.
  always_comb begin
    state_d         = state_q;
    clear_pending_d = clear_pending_q;
    mem_we_d        = mem_we_q;
    mem_addr_d      = mem_addr_q;
    mem_data_d      = mem_data_q;
    case (state_q)
      S_IDLE: begin
        if (push) begin
          state_d = S_DRAIN;
          if (clear_req) clear_pending_d = 1'b1;
        end else if (clear_req) begin
          state_d    = S_CLEAR;
          mem_we_d   = 1'b1;
          mem_addr_d = '0;
          mem_data_d = CLEAR_COLOUR;
        end
      end
      S_DRAIN: begin
        if (clear_req) clear_pending_d = 1'b1;
        if (count_d == '0) begin
          if (clear_pending_q | clear_req) begin
            state_d         = S_CLEAR;
            clear_pending_d = 1'b0;
            mem_we_d        = 1'b1;
            mem_addr_d      = '0;
            mem_data_d      = CLEAR_COLOUR;
          end else begin
            state_d  = S_IDLE;
            mem_we_d = 1'b0;
          end
        end else if (!mem_we_q || xfer) begin
          if (avail != '0) begin
            mem_we_d   = 1'b1;
            mem_addr_d = head[EW-1:3];
            mem_data_d = head[2:0];
          end else begin
            mem_we_d = 1'b0;
          end
        end
      end
      S_CLEAR: begin
        if (xfer) begin
          if (mem_addr_q == LAST_ADDR) begin
            state_d    = S_IDLE;
            mem_we_d   = 1'b0;
            mem_addr_d = '0;
          end else begin
            mem_addr_d = mem_addr_q + 15'd1;
          end
        end
      end
      default: begin
        state_d  = S_IDLE;
        mem_we_d = 1'b0;
      end
    endcase
  end

  // Sticky error flags; clr_flags takes priority over a same-cycle event.
  always_comb begin
    overflow_d   = overflow_q;
    drop_count_d = drop_count_q;
    if (clr_flags) begin
      overflow_d   = 1'b0;
      drop_count_d = '0;
    end else begin
      if (plot && full) overflow_d = 1'b1;
      if (plot && !full && !in_range && (drop_count_q != 8'hFF))
        drop_count_d = drop_count_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= S_IDLE;
      clear_pending_q <= 1'b0;
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      count_q         <= '0;
      mem_we_q        <= 1'b0;
      mem_addr_q      <= '0;
      mem_data_q      <= '0;
      overflow_q      <= 1'b0;
      drop_count_q    <= '0;
    end else begin
      state_q         <= state_d;
      clear_pending_q <= clear_pending_d;
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      count_q         <= count_d;
      mem_we_q        <= mem_we_d;
      mem_addr_q      <= mem_addr_d;
      mem_data_q      <= mem_data_d;
      overflow_q      <= overflow_d;
      drop_count_q    <= drop_count_d;
    end
  end

  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_data   = mem_data_q;
  assign overflow   = overflow_q;
  assign drop_count = drop_count_q;

endmodule

// File: tb/tb_plot_sink.sv
// Bench for plot_sink: queue-based reference model checked every cycle, plus
// directed scenarios with hand-computed write addresses and flag values.
module tb_plot_sink;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [7:0]  x;
  logic [6:0]  y;
  logic [2:0]  colour;
  logic        plot, clear_req, clr_flags, mem_ready;
  logic        full, busy, mem_we, overflow;
  logic [14:0] mem_addr;
  logic [2:0]  mem_data;
  logic [7:0]  drop_count;

  plot_sink dut (
    .clk(clk), .reset_n(reset_n), .x(x), .y(y), .colour(colour), .plot(plot),
    .clear_req(clear_req), .clr_flags(clr_flags), .full(full), .busy(busy),
    .mem_addr(mem_addr), .mem_data(mem_data), .mem_we(mem_we),
    .mem_ready(mem_ready), .overflow(overflow), .drop_count(drop_count)
  );

  always #10 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: pending plots carry the cycle they were accepted in and
  // become presentable on any later cycle.
  typedef struct {
    int a;
    int d;
    int t;
  } ent_t;

  ent_t mq[$];
  int   cyc     = 0;
  bit   m_pend  = 0;
  bit   m_clr   = 0;
  int   m_caddr = 0;
  bit   m_ovf   = 0;
  int   m_drop  = 0;
  bit   e_we    = 0;
  int   e_addr  = 0;
  int   e_data  = 0;
  bit   e_full  = 0;
  bit   e_busy  = 0;
  bit   full_pre, clr_pre, xf, inr;

  function automatic void model_outputs();
    e_we   = m_clr || (mq.size() > 0 && mq[0].t < cyc);
    e_addr = m_clr ? m_caddr : (mq.size() > 0 ? mq[0].a : 0);
    e_data = m_clr ? 0 : (mq.size() > 0 ? mq[0].d : 0);
    e_full = (mq.size() == 8) || m_pend || m_clr;
    e_busy = (mq.size() > 0) || m_pend || m_clr;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mq.delete();
      m_pend = 0; m_clr = 0; m_caddr = 0; m_ovf = 0; m_drop = 0; cyc = 0;
    end else begin
      full_pre = e_full;
      clr_pre  = m_clr;
      xf       = e_we && mem_ready;
      inr      = (x < 160) && (y < 120);
      cyc++;
      if (xf) begin
        if (m_clr) begin
          if (m_caddr == 19199) begin m_clr = 0; m_caddr = 0; end
          else m_caddr++;
        end else begin
          void'(mq.pop_front());
        end
      end
      if (clr_flags) begin
        m_ovf = 0; m_drop = 0;
      end else begin
        if (plot && full_pre) m_ovf = 1;
        if (plot && !full_pre && !inr && m_drop < 255) m_drop++;
      end
      if (plot && !full_pre && inr)
        mq.push_back('{a: int'(y) * 160 + int'(x), d: int'(colour), t: cyc});
      if (clear_req && !clr_pre) m_pend = 1;
      if (m_pend && mq.size() == 0 && !m_clr) begin
        m_clr = 1; m_caddr = 0; m_pend = 0;
      end
    end
    model_outputs();
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    chk("mem_we", int'(mem_we), int'(e_we));
    if (e_we) begin
      chk("mem_addr", int'(mem_addr), e_addr);
      chk("mem_data", int'(mem_data), e_data);
    end
    chk("full", int'(full), int'(e_full));
    chk("busy", int'(busy), int'(e_busy));
    chk("overflow", int'(overflow), int'(m_ovf));
    chk("drop_count", int'(drop_count), m_drop);
  end

  ent_t wr_log[$];
  always @(posedge clk) begin
    if (reset_n && mem_we && mem_ready)
      wr_log.push_back('{a: int'(mem_addr), d: int'(mem_data), t: 0});
  end

  task automatic do_plot(input int px, input int py, input int pc);
    x = 8'(px); y = 7'(py); colour = 3'(pc); plot = 1'b1;
    @(negedge clk);
    plot = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget && busy; i++) @(negedge clk);
    chk("wait_idle_busy", int'(busy), 0);
  endtask

  initial begin
    x = '0; y = '0; colour = '0; plot = 1'b0; clear_req = 1'b0; clr_flags = 1'b0;
    mem_ready = 1'b1; reset_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_we", int'(mem_we), 0);
    chk("rst_full", int'(full), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_addr", int'(mem_addr), 0);
    reset_n = 1'b1;
    @(negedge clk);

    // Single pixel
    wr_log.delete();
    do_plot(3, 2, 5);
    wait_idle(20);
    chk("t1_nwr", wr_log.size(), 1);
    chk("t1_addr", wr_log[0].a, 323);
    chk("t1_data", wr_log[0].d, 5);

    // Fill while stalled, overflow, then drain
    wr_log.delete();
    mem_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      do_plot(10 + i, i, i);
      if (i == 7) chk("t2_full8", int'(full), 1);
    end
    chk("t2_ovf", int'(overflow), 1);
    clr_flags = 1'b1;
    do_plot(20, 20, 1);
    clr_flags = 1'b0;
    chk("t2_ovf_clr_wins", int'(overflow), 0);
    repeat (3) @(negedge clk);
    mem_ready = 1'b1;
    wait_idle(40);
    chk("t2_nwr", wr_log.size(), 8);
    chk("t2_addr0", wr_log[0].a, 10);
    chk("t2_addr3", wr_log[3].a, 493);
    chk("t2_addr7", wr_log[7].a, 1137);
    chk("t2_data7", wr_log[7].d, 7);

    // Range boundaries
    wr_log.delete();
    do_plot(160, 0, 1);
    do_plot(0, 120, 2);
    do_plot(159, 119, 6);
    wait_idle(20);
    chk("t3_drop", int'(drop_count), 2);
    chk("t3_nwr", wr_log.size(), 1);
    chk("t3_addr", wr_log[0].a, 19199);
    chk("t3_data", wr_log[0].d, 6);
    clr_flags = 1'b1;
    @(negedge clk);
    clr_flags = 1'b0;
    chk("t3_drop_clr", int'(drop_count), 0);

    // Drop counter saturation
    for (int i = 0; i < 260; i++) do_plot(200, 3, 0);
    chk("t4_drop_sat", int'(drop_count), 255);
    clr_flags = 1'b1;
    do_plot(200, 3, 0);
    clr_flags = 1'b0;
    chk("t4_drop_clr_wins", int'(drop_count), 0);

    // Queued plots then a clear sweep
    wr_log.delete();
    mem_ready = 1'b0;
    do_plot(1, 0, 3);
    do_plot(2, 0, 4);
    do_plot(3, 0, 5);
    clear_req = 1'b1;
    @(negedge clk);
    clear_req = 1'b0;
    chk("t5_full_pending", int'(full), 1);
    repeat (2) @(negedge clk);
    mem_ready = 1'b1;
    wait_idle(19300);
    chk("t5_nwr", wr_log.size(), 19203);
    chk("t5_addr0", wr_log[0].a, 1);
    chk("t5_addr2", wr_log[2].a, 3);
    chk("t5_data2", wr_log[2].d, 5);
    chk("t5_clr_first", wr_log[3].a, 0);
    chk("t5_clr_first_d", wr_log[3].d, 0);
    chk("t5_clr_last", wr_log[19202].a, 19199);

    // Plot and clear_req together from idle: pixel drawn, then erased
    wr_log.delete();
    clear_req = 1'b1;
    do_plot(5, 5, 7);
    clear_req = 1'b0;
    wait_idle(19300);
    chk("t5b_nwr", wr_log.size(), 19201);
    chk("t5b_addr0", wr_log[0].a, 805);
    chk("t5b_data0", wr_log[0].d, 7);
    chk("t5b_clr_last", wr_log[19200].a, 19199);

    // Asynchronous reset mid-sweep
    clear_req = 1'b1;
    @(negedge clk);
    clear_req = 1'b0;
    for (int i = 0; i < 6000 && !(mem_we && mem_addr == 15'd5000); i++) @(negedge clk);
    chk("t6_at5000", int'(mem_addr), 5000);
    #3 reset_n = 1'b0;
    #1;
    chk("t6_rst_we", int'(mem_we), 0);
    chk("t6_rst_busy", int'(busy), 0);
    @(negedge clk);
    reset_n = 1'b1;
    wr_log.delete();
    @(negedge clk);
    do_plot(1, 1, 2);
    wait_idle(20);
    repeat (3) @(negedge clk);
    chk("t6_nwr", wr_log.size(), 1);
    chk("t6_addr", wr_log[0].a, 161);
    chk("t6_data", wr_log[0].d, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/plot_sink.md
Name: plot_sink

Overview:
- Receiving end of the pixel plot interface (x, y, colour, plot) driven by the movement/drawing datapaths.
- Buffers plot requests in a small FIFO and range-checks each one.
- Converts accepted requests to linear framebuffer addresses and drains them to a 160x120, 3-bit framebuffer write port using a ready/valid handshake.
- Also runs a full-screen clear sweep on request.
- Sits between drawing FSM/datapaths and the framebuffer memory.

Parameters:
- DEPTH, 8, FIFO entries (power of two, 2..64)
- SCREEN_W, 160, visible width in pixels
- SCREEN_H, 120, visible height in pixels
- CLEAR_COLOUR, 3'b000, colour written by the clear sweep

Ports:
- clk  in  1  system clock (50 MHz)
- reset_n  in  1  asynchronous active-low reset
- x  in  8  plot column
- y  in  7  plot row
- colour  in  3  plot colour
- plot  in  1  write request, one pixel per cycle high
- clear_req  in  1  one-cycle pulse, request full-screen clear
- clr_flags  in  1  one-cycle pulse, clear overflow and drop_count
- full  out  1  FIFO cannot accept; writer must hold off
- busy  out  1  FIFO non-empty, clear pending, or clear in progress
- mem_addr  out  15  framebuffer address = y*SCREEN_W + x
- mem_data  out  3  framebuffer write data
- mem_we  out  1  write valid
- mem_ready  in  1  framebuffer accepts write this cycle
- overflow  out  1  sticky: a plot was refused because full was high
- drop_count  out  8  saturating count of out-of-range plots

Behaviour:
- Reset (async, reset_n low):
  - FIFO empty; state IDLE; clear_pending=0.
  - All outputs 0 except full=0.
  - Any in-progress clear or drain is abandoned.
- Push:
  - Occurs when plot=1, full=0, x<SCREEN_W and y<SCREEN_H.
  - Entry stores {addr, colour}. addr is computed at push time as (y<<7)+(y<<5)+x, 15-bit.
- Out-of-range plot (x>=SCREEN_W or y>=SCREEN_H) with full=0:
  - Not stored.
  - drop_count+1, saturating at 255.
- Refused plot: plot=1 while full=1 is not stored and sets overflow. The range check is skipped, so drop_count is unchanged.
- full:
  - Combinational: (count==DEPTH) | clear_pending | (state==CLEAR).
  - A pop in the same cycle does not free a slot for a push.
- Output stage:
  - First-word-fall-through, registered.
  - A plot pushed into an empty FIFO at edge N shows mem_we=1 with its addr/data after edge N+1, i.e. one cycle of latency.
- Handshake:
  - A transfer occurs on an edge where mem_we & mem_ready.
  - mem_addr, mem_data and mem_we hold stable while mem_we=1 and mem_ready=0.
  - Back-to-back transfers sustain 1 per cycle.
- States:
  - IDLE: FIFO empty, mem_we=0.
    - Push → DRAIN.
    - clear_req → CLEAR, taken on the next edge.
  - DRAIN: pops entries.
    - Goes to IDLE when the last entry transfers.
    - clear_req sets clear_pending. Push is then blocked; FIFO entries already queued still drain.
    - When FIFO empties with clear_pending=1 → CLEAR, and clear_pending clears.
  - CLEAR:
    - Drives mem_data=CLEAR_COLOUR, mem_we=1, mem_addr counter from 0.
    - Counter advances on each transfer.
    - After the transfer at SCREEN_W*SCREEN_H-1 (19199) → IDLE, counter returns to 0.
    - clear_req during CLEAR is ignored.
    - A sweep takes 19200 transfers.
- busy = (state!=IDLE) | clear_pending.
- Simultaneous events:
  - clear_req with plot in the same cycle in IDLE: the plot is pushed first, state → DRAIN with clear_pending=1, so the pixel is drawn and then erased.
  - clr_flags with an overflow/drop event in the same cycle: the clear wins; both flags read 0 afterwards.
- Address width: x max 159, y max 119 → max addr 19199 fits in 15 bits; no wrap.
- FIFO pointers are log2(DEPTH) bits and wrap modulo DEPTH; count is log2(DEPTH)+1 bits.

Test Plan:
- Reset, mem_ready=1, one plot at (x=3, y=2, colour=5):
  - mem_we=1 for exactly one cycle, one cycle after the push.
  - mem_addr=323, mem_data=5.
  - busy returns to 0.
- mem_ready=0, plot 9 pixels back-to-back (DEPTH=8):
  - full rises after the 8th push; the 9th sets overflow=1.
  - With mem_ready=1 afterwards, exactly 8 writes occur, in push order.
  - mem_addr/mem_data/mem_we stay stable while stalled.
- Plots at (160,0), (0,120) and (159,119):
  - drop_count=2.
  - A single write occurs with mem_addr=19199.
  - clr_flags sets drop_count=0.
- 256+ out-of-range plots: drop_count saturates at 255 and never wraps to 0.
- Queue 3 plots with mem_ready=0, then clear_req, then mem_ready=1:
  - The 3 plot writes complete first.
  - Then 19200 writes follow, addresses 0..19199 with colour 0.
  - full=1 throughout; busy drops only after addr 19199.
- Assert reset_n=0 mid-clear at address 5000:
  - mem_we=0 and busy=0 immediately (asynchronous).
  - After release, a plot drains normally and the clear does not resume.
